// File: rtl/systolic_pkg.sv
// Shared types and parameter derivations for the output-stationary systolic matrix multiplier.
package systolic_pkg;

    localparam int SYS_N_DEFAULT    = 4;
    localparam int SYS_DW_DEFAULT   = 8;
    localparam int SYS_KMAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int calc_acc_w(input int dw, input int kmax);
        return 2 * dw + $clog2(kmax);
    endfunction

    function automatic int calc_kw(input int kmax);
        return $clog2(kmax + 1);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell; forwards a right and b down one enabled step later.
// SYSTOLIC_SIGNED_EN selects two's-complement operands, otherwise unsigned.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW    = SYS_DW_DEFAULT,
    parameter int ACC_W = calc_acc_w(SYS_DW_DEFAULT, SYS_KMAX_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic [ACC_W-1:0] acc
);

    logic [DW-1:0]    a_r;
    logic [DW-1:0]    b_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] a_ext_s;
    logic [ACC_W-1:0] b_ext_s;
    logic [ACC_W-1:0] prod_s;

    // Extend operands to the accumulator width; the low ACC_W bits of the product are exact.
    always_comb begin
`ifdef SYSTOLIC_SIGNED_EN
        a_ext_s = {{(ACC_W-DW){a_in[DW-1]}}, a_in};
        b_ext_s = {{(ACC_W-DW){b_in[DW-1]}}, b_in};
`else
        a_ext_s = {{(ACC_W-DW){1'b0}}, a_in};
        b_ext_s = {{(ACC_W-DW){1'b0}}, b_in};
`endif
        prod_s = a_ext_s * b_ext_s;
    end

    // Accumulate and forward operands on each enabled step.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (en) begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= acc_r + prod_s;
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign acc   = acc_r;

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic array computing C = A x B with skewed operand injection.
// SYSTOLIC_SIGNED_EN selects two's-complement operands, otherwise unsigned.
module systolic_matmul
    import systolic_pkg::*;
#(
    parameter  int N     = SYS_N_DEFAULT,
    parameter  int DW    = SYS_DW_DEFAULT,
    parameter  int KMAX  = SYS_KMAX_DEFAULT,
    localparam int ACC_W = calc_acc_w(DW, KMAX),
    localparam int KW    = calc_kw(KMAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*DW-1:0]    a_col,
    input  logic [N*DW-1:0]    b_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*ACC_W-1:0] out_row,
    output logic               out_last,
    output logic               busy
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [KW-1:0]        k_len_r;
    logic [KW-1:0]        k_eff_s;
    logic [KW-1:0]        beat_cnt_r;
    logic [FW-1:0]        flush_cnt_r;
    logic [RW-1:0]        row_idx_r;
    logic [RW-1:0]        sel_idx_s;
    logic                 beat_s;
    logic                 adv_s;
    logic                 clr_s;
    logic                 in_ready_r;
    logic                 busy_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [N*ACC_W-1:0]   out_row_r;
    logic [N*ACC_W-1:0]   row_sel_s;

    logic [DW-1:0]        a_gate_s   [N];
    logic [DW-1:0]        b_gate_s   [N];
    logic [DW-1:0]        a_lane_s   [N];
    logic [DW-1:0]        b_lane_s   [N];
    logic [DW-1:0]        a_bus_s    [N][N-1];
    logic [DW-1:0]        b_bus_s    [N-1][N];
    logic [DW-1:0]        unused_a_s [N];
    logic [DW-1:0]        unused_b_s [N];
    logic [ACC_W-1:0]     acc_s      [N][N];

    // Job control decode; zeros are injected whenever no beat is being accepted.
    always_comb begin
        k_eff_s   = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
        beat_s    = (state_r == ST_LOAD) && in_valid;
        adv_s     = beat_s || (state_r == ST_FLUSH);
        clr_s     = (state_r == ST_IDLE) && start;
        sel_idx_s = (state_r == ST_DRAIN) ? (row_idx_r + RW'(1)) : '0;
        for (int i = 0; i < N; i++) begin
            a_gate_s[i] = beat_s ? a_col[i*DW +: DW] : '0;
            b_gate_s[i] = beat_s ? b_row[i*DW +: DW] : '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (k_eff_s == '0) ? ST_DRAIN : ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid && (beat_cnt_r == (k_len_r - KW'(1)))) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FW'(2*N-2)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (out_ready && (row_idx_r == RW'(N-1))) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Row multiplexer: row 0 while flushing, the following row while draining.
    always_comb begin
        row_sel_s = '0;
        for (int j = 0; j < N; j++) begin
            row_sel_s[j*ACC_W +: ACC_W] = acc_s[sel_idx_s][j];
        end
    end

    // Counters, latched job length and the registered result interface.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_len_r     <= '0;
            beat_cnt_r  <= '0;
            flush_cnt_r <= '0;
            row_idx_r   <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_row_r   <= '0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r     <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        k_len_r    <= k_eff_s;
                        beat_cnt_r <= '0;
                        if (k_eff_s == '0) begin
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b0;
                            out_row_r   <= '0;
                            row_idx_r   <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    flush_cnt_r <= '0;
                    if (in_valid) begin
                        beat_cnt_r <= beat_cnt_r + KW'(1);
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_r <= flush_cnt_r + FW'(1);
                    if (flush_cnt_r == FW'(2*N-2)) begin
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        out_row_r   <= row_sel_s;
                        row_idx_r   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (row_idx_r == RW'(N-1)) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            row_idx_r  <= sel_idx_s;
                            out_row_r  <= row_sel_s;
                            out_last_r <= (sel_idx_s == RW'(N-1));
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign a_lane_s[gi] = a_gate_s[gi];
                assign b_lane_s[gi] = b_gate_s[gi];
            end else begin : g_delay
                logic [DW-1:0] a_sr_r [0:gi-1];
                logic [DW-1:0] b_sr_r [0:gi-1];
                // Lane gi is delayed gi array steps so operands meet in the right PE.
                always_ff @(posedge clk) begin
                    if (reset || clr_s) begin
                        for (int s = 0; s < gi; s++) begin
                            a_sr_r[s] <= '0;
                            b_sr_r[s] <= '0;
                        end
                    end else if (adv_s) begin
                        a_sr_r[0] <= a_gate_s[gi];
                        b_sr_r[0] <= b_gate_s[gi];
                        for (int s = 1; s < gi; s++) begin
                            a_sr_r[s] <= a_sr_r[s-1];
                            b_sr_r[s] <= b_sr_r[s-1];
                        end
                    end
                end
                assign a_lane_s[gi] = a_sr_r[gi-1];
                assign b_lane_s[gi] = b_sr_r[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DW-1:0] a_in_s;
                logic [DW-1:0] b_in_s;
                logic [DW-1:0] a_out_s;
                logic [DW-1:0] b_out_s;

                if (gj == 0) begin : g_a_edge
                    assign a_in_s = a_lane_s[gi];
                end else begin : g_a_mid
                    assign a_in_s = a_bus_s[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign b_in_s = b_lane_s[gj];
                end else begin : g_b_mid
                    assign b_in_s = b_bus_s[gi-1][gj];
                end
                if (gj < N - 1) begin : g_a_fwd
                    assign a_bus_s[gi][gj] = a_out_s;
                end else begin : g_a_end
                    assign unused_a_s[gi] = a_out_s;
                end
                if (gi < N - 1) begin : g_b_fwd
                    assign b_bus_s[gi][gj] = b_out_s;
                end else begin : g_b_end
                    assign unused_b_s[gj] = b_out_s;
                end

                systolic_pe #(
                    .DW    (DW),
                    .ACC_W (ACC_W)
                ) u_pe (
                    .clk   (clk),
                    .reset (reset),
                    .en    (adv_s),
                    .clr   (clr_s),
                    .a_in  (a_in_s),
                    .b_in  (b_in_s),
                    .a_out (a_out_s),
                    .b_out (b_out_s),
                    .acc   (acc_s[gi][gj])
                );
            end
        end
    endgenerate

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_row   = out_row_r;

endmodule

// File: tb/tb_systolic_matmul.sv
// Scoreboard bench for systolic_matmul: golden C rows queued per job, compared on each handshake.
module tb_systolic_matmul;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int KMAX  = 16;
    localparam int ACC_W = 2 * DW + $clog2(KMAX);
    localparam int KW    = $clog2(KMAX + 1);
    localparam int RWID  = N * ACC_W;

    typedef struct packed {
        logic [RWID-1:0] row;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic            out_valid;
    logic            out_ready;
    logic [RWID-1:0] out_row;
    logic            out_last;
    logic            busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic [DW-1:0] am [N][KMAX];
    logic [DW-1:0] bm [KMAX][N];

    always #5 clk = ~clk;

    systolic_matmul #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint opv(input logic [DW-1:0] v);
`ifdef SYSTOLIC_SIGNED_EN
        return longint'($signed(v));
`else
        return longint'(v);
`endif
    endfunction

    task automatic push_expected(input int k);
        for (int r = 0; r < N; r++) begin
            exp_t e;
            e.row  = '0;
            e.last = (r == N - 1);
            for (int j = 0; j < N; j++) begin
                longint      sum = 0;
                logic [63:0] s;
                for (int kk = 0; kk < k; kk++) sum += opv(am[r][kk]) * opv(bm[kk][j]);
                s = sum;
                e.row[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input int idx);
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = am[i][idx];
            b_row[i*DW +: DW] = bm[idx][i];
        end
    endtask

    task automatic drain(input bit stalls, input bit poke_start);
        int              got = 0;
        int              guard = 0;
        bit              held_v = 1'b0;
        logic [RWID-1:0] held_row = '0;
        while (got < N && guard < 500) begin
            if (held_v) check_eq("hold_row", out_row, held_row);
            if (poke_start && guard == 0) begin
                start = 1'b1;
                k_len = KW'(3);
            end else begin
                start = 1'b0;
            end
            out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v   = out_valid && !out_ready;
            held_row = out_row;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_row", 1, 0);
                end else begin
                    exp_t e = exp_q.pop_front();
                    check_eq("row", out_row, e.row);
                    check_eq("last", out_last, e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            guard++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (got < N) check_eq("drain_timeout", got, N);
        check_eq("valid_drop", out_valid, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic run_job(input int kreq, input bit gaps, input bit stalls, input bit poke_start);
        int keff = (kreq > KMAX) ? KMAX : kreq;
        int idx = 0;
        int guard = 0;
        int lat = 0;
        bit acc;
        push_expected(keff);
        start = 1'b1;
        k_len = KW'(kreq);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        if (keff > 0) begin
            while (idx < keff && guard < 1000) begin
                in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (in_valid) drive_beat(idx);
                else begin
                    a_col = $urandom;
                    b_row = $urandom;
                end
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc) idx++;
                guard++;
            end
            in_valid = 1'b0;
            if (idx < keff) check_eq("load_timeout", idx, keff);
            check_eq("ready_after_load", in_ready, 0);
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check_eq("latency", lat, 2 * N - 1);
        end else begin
            check_eq("zero_k_valid", out_valid, 1);
        end
        drain(stalls, poke_start);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                am[i][k] = DW'($urandom);
                bm[k][i] = DW'($urandom);
            end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                am[i][k] = av;
                bm[k][i] = bv;
            end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_row", out_row, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Identity A: C equals B.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                am[i][k] = (i == k) ? DW'(1) : DW'(0);
                bm[k][i] = DW'(4 * k + i + 1);
            end
        run_job(4, 1'b0, 1'b0, 1'b0);

        // Full-scale operands, K = KMAX.
        fill_const(8'hFF, 8'hFF);
        run_job(16, 1'b0, 1'b0, 1'b0);

`ifdef SYSTOLIC_SIGNED_EN
        fill_const(8'h80, 8'h80);
        run_job(16, 1'b0, 1'b0, 1'b0);
        fill_const(8'hFF, 8'h01);
        run_job(3, 1'b0, 1'b0, 1'b0);
`endif

        // Random data with input gaps and output stalls.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_job(7, 1'b1, 1'b1, 1'b0);
        end

        // Oversized k_len clamps to KMAX.
        fill_random();
        run_job(KMAX + 4, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of LOAD, then a clean job.
        fill_random();
        start = 1'b1; k_len = KW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        fill_random();
        run_job(5, 1'b1, 1'b0, 1'b0);

        // Empty job with a start pulse during DRAIN that must be ignored.
        run_job(0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("no_second_job", busy, 0);
        end

        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 Parameter N, default 4, array rows/columns (N x N output-stationary PEs), N >= 2.
REQ-002 Parameter DW, default 8, operand width.
REQ-003 Parameter KMAX, default 16, maximum inner dimension per job.
REQ-004 Localparam ACC_W = 2*DW + clog2(KMAX); KW = clog2(KMAX+1).
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  job request; sampled only in IDLE.
REQ-008 k_len  in  KW  inner dimension K, sampled with accepted start.
REQ-009 in_valid  in  1  a_col/b_row beat valid.
REQ-010 in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-011 a_col  in  N*DW  column k of A; row i in bits [i*DW +: DW].
REQ-012 b_row  in  N*DW  row k of B; column j in bits [j*DW +: DW].
REQ-013 out_valid  out  1  result row valid.
REQ-014 out_ready  in  1  result row consumed when out_valid && out_ready.
REQ-015 out_row  out  N*ACC_W  row r of C; C[r][j] in bits [j*ACC_W +: ACC_W].
REQ-016 out_last  out  1  high with out_valid on row N-1.
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 Computes C = A x B, A N x K, B K x N, one k per accepted beat.
REQ-019 FSM states IDLE, LOAD, FLUSH, DRAIN.
REQ-020 IDLE: start=1 clears all accumulators, latches k_len; k_len>0 -> LOAD, k_len=0 -> DRAIN (all-zero C).
REQ-021 LOAD: in_ready=1; after k_len accepted beats -> FLUSH; in_ready=0 in all other states.
REQ-022 Input skew: a_col lane i delayed i cycles, b_row lane j delayed j cycles, via per-lane shift registers.
REQ-023 Array and skew registers advance only on an accepted beat or in FLUSH; in_valid gaps insert no bubbles and leave results unchanged.
REQ-024 FLUSH lasts exactly 2N-1 cycles, feeding zeros, then -> DRAIN.
REQ-025 DRAIN: rows presented in order r = 0..N-1; out_row stable while out_valid && !out_ready.
REQ-026 Handshake on row N-1 (out_last) -> IDLE; out_valid deasserts the following cycle.
REQ-027 start outside IDLE is ignored; k_len > KMAX is clamped to KMAX.
REQ-028 Each PE: acc <= acc + a*b (full 2*DW product, extended to ACC_W); a/b forwarded right/down one cycle later.
REQ-029 Accumulation wraps modulo 2^ACC_W; no overflow for K <= KMAX.
REQ-030 Latency: first out_valid exactly 2N cycles after the last accepted beat.

Reset
REQ-031 reset forces IDLE from any state, including mid-LOAD/FLUSH/DRAIN; the job is discarded.
REQ-032 Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0, all accumulators, skew and PE pipeline registers 0.

Configuration
REQ-033 Macro SYSTOLIC_SIGNED_EN defined: operands are two's-complement, products sign-extended to ACC_W.
REQ-034 SYSTOLIC_SIGNED_EN undefined: operands unsigned, zero-extended.

Structure
REQ-035 Package systolic_pkg holds the FSM state enum, the ACC_W/KW derivation functions and default parameter constants.
REQ-036 Sub-module systolic_pe (one MAC cell, with enable and clear inputs) is instantiated N*N times via generate.

Verification
REQ-037 N=4, DW=8, A=identity, K=4, B rows {1,2,3,4}..{13,14,15,16} -> out_row r equals B row r, out_last on beat 4.
REQ-038 Unsigned, all operands 255, K=16 -> every C element 1040400, no wrap.
REQ-039 SYSTOLIC_SIGNED_EN, all operands -128, K=16 -> every C element 262144; a=-1, b=1, K=3 -> -3.
REQ-040 Random A/B, K=7, in_valid 50% random gaps, out_ready toggling -> C matches golden model, out_row held under stall.
REQ-041 reset asserted at LOAD beat 3 -> next cycle busy=0, in_ready=0; new job returns correct C with no residue.
REQ-042 k_len=0 -> 4 all-zero rows; start pulsed during DRAIN -> ignored, no second job.
